// File: rtl/md_ctrl.sv
// Multiply/divide unit control: holds HI/LO, runs multi-cycle mult/div with a
// fixed busy latency and raises the stall request for dependent D-stage ops.
module md_ctrl #(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        md_use_D,
    output logic        busy,
    output logic        stall_md,
    output logic [31:0] High,
    output logic [31:0] Low
);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic [31:0] pend_hi, pend_lo;
    logic        pend_wr;

    logic ld_mul, ld_div, wr_mthi, wr_mtlo, commit;
    logic is_mul, is_div;

    // Result datapath (evaluated every cycle, captured only on issue)
    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic        [63:0] prod;
    logic               div_sgn, a_neg, b_neg;
    logic        [31:0] a_mag, b_mag, b_safe, q_mag, r_mag, quot, rem;

    assign is_mul = (md_op == OP_MULT) || (md_op == OP_MULTU);
    assign is_div = (md_op == OP_DIV)  || (md_op == OP_DIVU);

    assign prod_s = $signed(rs_val) * $signed(rt_val);
    assign prod_u = {32'b0, rs_val} * {32'b0, rt_val};
    assign prod   = (md_op == OP_MULT) ? prod_s : prod_u;

    // Signed division done on magnitudes so truncation toward zero and the
    // dividend-signed remainder fall out directly, including -2^31 / -1.
    assign div_sgn = (md_op == OP_DIV);
    assign a_neg   = div_sgn & rs_val[31];
    assign b_neg   = div_sgn & rt_val[31];
    assign a_mag   = a_neg ? -rs_val : rs_val;
    assign b_mag   = b_neg ? -rt_val : rt_val;
    assign b_safe  = (b_mag == 32'd0) ? 32'd1 : b_mag;
    assign q_mag   = a_mag / b_safe;
    assign r_mag   = a_mag % b_safe;
    assign quot    = (a_neg ^ b_neg) ? -q_mag : q_mag;
    assign rem     = a_neg ? -r_mag : r_mag;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ld_mul    = 1'b0;
        ld_div    = 1'b0;
        wr_mthi   = 1'b0;
        wr_mtlo   = 1'b0;
        commit    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (is_mul) begin
                        ld_mul    = 1'b1;
                        cnt_nxt   = 4'(MULT_CYC);
                        state_nxt = BUSY;
                    end else if (is_div) begin
                        ld_div    = 1'b1;
                        cnt_nxt   = 4'(DIV_CYC);
                        state_nxt = BUSY;
                    end else if (md_op == OP_MTHI) begin
                        wr_mthi = 1'b1;
                    end else if (md_op == OP_MTLO) begin
                        wr_mtlo = 1'b1;
                    end
                end
            end
            BUSY: begin
                // cnt <= 1 also covers a degenerate zero count
                if (cnt <= 4'd1) begin
                    commit    = 1'b1;
                    cnt_nxt   = 4'd0;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pend_hi <= 32'd0;
            pend_lo <= 32'd0;
            pend_wr <= 1'b0;
            High    <= 32'd0;
            Low     <= 32'd0;
        end else begin
            if (ld_mul) begin
                pend_hi <= prod[63:32];
                pend_lo <= prod[31:0];
                pend_wr <= 1'b1;
            end else if (ld_div) begin
                // Divide by zero keeps the pending pair and suppresses the write
                pend_wr <= (rt_val != 32'd0);
                if (rt_val != 32'd0) begin
                    pend_hi <= rem;
                    pend_lo <= quot;
                end
            end
            if (commit && pend_wr) begin
                High <= pend_hi;
                Low  <= pend_lo;
            end
            if (wr_mthi) High <= rs_val;
            if (wr_mtlo) Low  <= rs_val;
        end
    end

    assign busy     = (state == BUSY);
    assign stall_md = md_use_D & (start | busy);

endmodule

// File: doc/md_ctrl.md
MD_CTRL -- requirements
Module: md_ctrl

Interface
REQ-001 Parameter MULT_CYC, default 5, busy cycles for mult/multu.
REQ-002 Parameter DIV_CYC, default 10, busy cycles for div/divu.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset; sampled on rising edge of clk.
REQ-005 start  input  1  E-stage MD instruction issue strobe, one cycle per instruction.
REQ-006 md_op  input  3  operation: 000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo; others no-op.
REQ-007 rs_val  input  32  forwarded rs operand from the E stage.
REQ-008 rt_val  input  32  forwarded rt operand from the E stage.
REQ-009 md_use_D  input  1  D-stage instruction is mult/multu/div/divu/mthi/mtlo/mfhi/mflo.
REQ-010 busy  output  1  operation in progress.
REQ-011 stall_md  output  1  stall request to the hazard unit.
REQ-012 High  output  32  architectural HI register.
REQ-013 Low  output  32  architectural LO register.

Function
REQ-014 The block SHALL have two states: IDLE and BUSY, plus a 4-bit down-counter cnt.
REQ-015 In IDLE, start with md_op in {mult, multu} SHALL latch the 64-bit product (signed/unsigned per op) into pend_hi/pend_lo, set cnt=MULT_CYC and enter BUSY.
REQ-016 In IDLE, start with md_op in {div, divu} and rt_val!=0 SHALL latch remainder into pend_hi and quotient into pend_lo, set cnt=DIV_CYC and enter BUSY.
REQ-017 Signed division SHALL truncate toward zero, with the remainder taking the sign of the dividend.
REQ-018 Division with rt_val==0 SHALL enter BUSY for DIV_CYC cycles and leave High/Low unchanged at completion.
REQ-019 In BUSY, cnt SHALL decrement each cycle.
REQ-020 When cnt==1 in BUSY, the next edge SHALL write High<=pend_hi and Low<=pend_lo (unless REQ-018 applies), clear busy and return to IDLE.
REQ-021 busy SHALL be a registered output equal to (state==BUSY).
REQ-022 busy SHALL be high for exactly MULT_CYC or DIV_CYC consecutive cycles, starting the cycle after start is sampled.
REQ-023 Following REQ-022, new High/Low values SHALL be visible in the first cycle busy is low.
REQ-024 In IDLE, start with mthi SHALL write High<=rs_val at that edge; with mtlo it SHALL write Low<=rs_val; state SHALL remain IDLE.
REQ-025 start while BUSY SHALL be ignored, with no change to state, cnt or pending values.
REQ-026 start with an undefined md_op SHALL be ignored.
REQ-027 stall_md SHALL be combinational and equal to md_use_D & (start | busy).
REQ-028 stall_md SHALL remain low when md_use_D=0, regardless of busy.
REQ-029 High and Low SHALL hold their values at all times except the updates in REQ-020 and REQ-024.

Reset
REQ-030 When reset=0 at a rising edge, the block SHALL set state=IDLE, cnt=0, busy=0, High=0, Low=0, pend_hi=0 and pend_lo=0.
REQ-031 Reset asserted mid-operation SHALL abort the operation with no High/Low write, and busy SHALL be 0 the following cycle.
REQ-032 Reset SHALL take priority over start.

Verification
REQ-033 mult with rs=0xFFFFFFFF, rt=0x00000002 -> busy high for 5 cycles, then High=0xFFFFFFFF, Low=0xFFFFFFFE.
REQ-034 multu with the same operands -> busy high for 5 cycles, then High=0x00000001, Low=0xFFFFFFFE.
REQ-035 div with rs=0xFFFFFFF9 (-7), rt=2 -> busy high for 10 cycles, then Low=0xFFFFFFFD (-3), High=0xFFFFFFFF (-1).
REQ-036 divu with rs=7, rt=0 after mthi 0x1234 and mtlo 0x5678 -> busy high for 10 cycles, then High=0x1234 and Low=0x5678 unchanged.
REQ-037 During a mult with md_use_D=1 on every busy cycle -> stall_md=1 for all 5 busy cycles and the start cycle; a second start issued during busy -> ignored.
REQ-038 reset=0 on busy cycle 3 of a div -> next cycle busy=0, High=0, Low=0; a subsequent mtlo 0xA5 -> Low=0xA5.
